// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout video/SPI blocks: line width, SPI opcodes
// and the block-state arbiter FSM encoding.
package breakout_pkg;

    localparam int   LINE_WIDTH   = 13;
    localparam logic SPI_OP_SHIFT = 1'b0;
    localparam logic SPI_OP_WRITE = 1'b1;

    typedef enum logic {
        ARB_IDLE,
        ARB_REALIGN
    } arb_state_t;

endpackage

// File: rtl/block_state_arbiter.sv
// Single owner of the block-line store control port: video ops pass straight through,
// buffered SPI ops run only in vblank, and the head row is re-aligned to 0 every frame.
module block_state_arbiter #(
    parameter int NUM_ROWS   = 16,
    parameter int LINE_WIDTH = breakout_pkg::LINE_WIDTH
) (
    input  logic                        clk,
    input  logic                        nRst,
    input  logic                        vblank,
    input  logic                        frame_pulse,
    input  logic                        vid_next,
    input  logic                        vid_write,
    input  logic [LINE_WIDTH-1:0]       vid_line,
    input  logic                        spi_valid,
    output logic                        spi_ready,
    input  logic                        spi_op,
    input  logic [LINE_WIDTH-1:0]       spi_line,
    output logic                        st_next,
    output logic                        st_write,
    output logic [LINE_WIDTH-1:0]       st_line,
    output logic [$clog2(NUM_ROWS)-1:0] head_idx,
    output logic                        busy
);

    import breakout_pkg::arb_state_t;
    import breakout_pkg::ARB_IDLE;
    import breakout_pkg::ARB_REALIGN;

    localparam int            IW       = $clog2(NUM_ROWS);
    localparam logic [IW-1:0] LAST_ROW = IW'(NUM_ROWS - 1);

    arb_state_t            state;
    logic                  pend;
    logic                  pend_op;
    logic [LINE_WIDTH-1:0] pend_line;

    logic                  vid_op;
    logic                  spi_go;
    logic [IW-1:0]         head_next;
    logic [IW-1:0]         head_after;

    assign vid_op     = vid_next || vid_write;
    assign spi_go     = pend && vblank && (state == ARB_IDLE) && !vid_op && !frame_pulse;
    assign head_next  = (head_idx == LAST_ROW) ? '0 : head_idx + IW'(1);
    assign head_after = st_next ? head_next : head_idx;

    assign spi_ready  = !pend;
    assign busy       = (state == ARB_REALIGN);

    // NOTE: every output gets a default before the priority chain so no latch is inferred.
    always_comb begin
        st_next  = 1'b0;
        st_write = 1'b0;
        st_line  = '0;
        if (vid_op) begin
            st_next  = vid_next;
            st_write = vid_write;
            st_line  = vid_line;
        end else if (state == ARB_REALIGN) begin
            st_next  = 1'b1;
        end else if (spi_go) begin
            st_next  = 1'b1;
            st_write = pend_op;
            st_line  = pend_line;
        end
    end

    // Frame start only triggers a realign if the head will not already sit on row 0.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= ARB_IDLE;
            head_idx <= '0;
        end else begin
            if (st_next) begin
                head_idx <= head_next;
            end
            if (state == ARB_IDLE) begin
                if (frame_pulse && (head_after != '0)) begin
                    state <= ARB_REALIGN;
                end
            end else if (st_next && (head_next == '0)) begin
                state <= ARB_IDLE;
            end
        end
    end

    // Accept and drain are mutually exclusive: accept needs an empty buffer, drain a full one.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pend      <= 1'b0;
            pend_op   <= 1'b0;
            pend_line <= '0;
        end else if (spi_go) begin
            pend      <= 1'b0;
        end else if (spi_valid && !pend) begin
            pend      <= 1'b1;
            pend_op   <= spi_op;
            pend_line <= spi_line;
        end
    end

endmodule

// File: tb/tb_block_state_arbiter.sv
// Directed bench for block_state_arbiter: video priority, vblank gating of SPI ops,
// frame re-alignment, wrap-around and asynchronous reset in the middle of a realign.
module tb_block_state_arbiter;

    import breakout_pkg::SPI_OP_SHIFT;
    import breakout_pkg::SPI_OP_WRITE;

    localparam int NUM_ROWS   = 16;
    localparam int LINE_WIDTH = 13;
    localparam int IW         = 4;

    logic                  clk;
    logic                  nRst;
    logic                  vblank;
    logic                  frame_pulse;
    logic                  vid_next;
    logic                  vid_write;
    logic [LINE_WIDTH-1:0] vid_line;
    logic                  spi_valid;
    logic                  spi_ready;
    logic                  spi_op;
    logic [LINE_WIDTH-1:0] spi_line;
    logic                  st_next;
    logic                  st_write;
    logic [LINE_WIDTH-1:0] st_line;
    logic [IW-1:0]         head_idx;
    logic                  busy;

    int vectors     = 0;
    int miscompares = 0;

    block_state_arbiter #(.NUM_ROWS(NUM_ROWS), .LINE_WIDTH(LINE_WIDTH)) dut (
        .clk(clk), .nRst(nRst), .vblank(vblank), .frame_pulse(frame_pulse),
        .vid_next(vid_next), .vid_write(vid_write), .vid_line(vid_line),
        .spi_valid(spi_valid), .spi_ready(spi_ready), .spi_op(spi_op), .spi_line(spi_line),
        .st_next(st_next), .st_write(st_write), .st_line(st_line),
        .head_idx(head_idx), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vblank      = 1'b0;
        frame_pulse = 1'b0;
        vid_next    = 1'b0;
        vid_write   = 1'b0;
        vid_line    = '0;
        spi_valid   = 1'b0;
        spi_op      = SPI_OP_SHIFT;
        spi_line    = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        nRst = 1'b0;
        step();
        step();
        nRst = 1'b1;
    endtask

    task automatic spi_shift();
        vblank    = 1'b1;
        spi_valid = 1'b1;
        spi_op    = SPI_OP_SHIFT;
        step();
        spi_valid = 1'b0;
        step();
        vblank    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRst = 1'b0;
        #3;
        vectors++;
        if ({st_next, st_write, st_line, head_idx, busy, spi_ready} !== {1'b0, 1'b0, 13'h0, 4'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_hold: got next=%b write=%b line=%h head=%0d busy=%b ready=%b expected 0 0 0000 0 0 1",
                     st_next, st_write, st_line, head_idx, busy, spi_ready);
        end
        step();
        nRst = 1'b1;
        step();
        #2;
        vectors++;
        if ({st_next, st_write, head_idx, busy, spi_ready} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_release: got next=%b write=%b head=%0d busy=%b ready=%b expected 0 0 0 0 1",
                     st_next, st_write, head_idx, busy, spi_ready);
        end
    endtask

    task automatic test_video_priority();
        apply_reset();
        vblank    = 1'b1;
        spi_valid = 1'b1;
        spi_op    = SPI_OP_WRITE;
        spi_line  = 13'h0555;
        vid_next  = 1'b1;
        vid_line  = 13'h0AAA;
        #2;
        vectors++;
        if ({st_next, st_write, st_line} !== {1'b1, 1'b0, 13'h0AAA}) begin
            miscompares++;
            $display("FAIL video_first: got next=%b write=%b line=%h expected 1 0 0aaa", st_next, st_write, st_line);
        end
        step();
        spi_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            vectors++;
            if ({st_next, st_write, spi_ready} !== {1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL video_hold_%0d: got next=%b write=%b ready=%b expected 1 0 0", i, st_next, st_write, spi_ready);
            end
            step();
        end
        vid_next = 1'b0;
        #2;
        vectors++;
        if ({st_next, st_write, st_line, head_idx} !== {1'b1, 1'b1, 13'h0555, 4'd3}) begin
            miscompares++;
            $display("FAIL spi_after_video: got next=%b write=%b line=%h head=%0d expected 1 1 0555 3",
                     st_next, st_write, st_line, head_idx);
        end
        step();
        #2;
        vectors++;
        if ({head_idx, spi_ready, st_next} !== {4'd4, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL spi_drained: got head=%0d ready=%b next=%b expected 4 1 0", head_idx, spi_ready, st_next);
        end
        vid_write = 1'b1;
        vid_line  = 13'h1234;
        #2;
        vectors++;
        if ({st_next, st_write, st_line} !== {1'b0, 1'b1, 13'h1234}) begin
            miscompares++;
            $display("FAIL video_write: got next=%b write=%b line=%h expected 0 1 1234", st_next, st_write, st_line);
        end
        step();
        vid_write = 1'b0;
        #2;
        vectors++;
        if (head_idx !== 4'd4) begin
            miscompares++;
            $display("FAIL write_no_shift: got head=%0d expected 4", head_idx);
        end
    endtask

    task automatic test_spi_blanking();
        vblank    = 1'b0;
        spi_valid = 1'b1;
        spi_op    = SPI_OP_WRITE;
        spi_line  = 13'h1ABC;
        #2;
        vectors++;
        if (spi_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL spi_offer_ready: got %b expected 1", spi_ready);
        end
        step();
        spi_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            vectors++;
            if ({spi_ready, st_next, st_write} !== 3'b000) begin
                miscompares++;
                $display("FAIL spi_gated_%0d: got ready=%b next=%b write=%b expected 0 0 0", i, spi_ready, st_next, st_write);
            end
            step();
        end
        vblank = 1'b1;
        #2;
        vectors++;
        if ({st_next, st_write, st_line} !== {1'b1, 1'b1, 13'h1ABC}) begin
            miscompares++;
            $display("FAIL spi_in_vblank: got next=%b write=%b line=%h expected 1 1 1abc", st_next, st_write, st_line);
        end
        step();
        vblank = 1'b0;
        #2;
        vectors++;
        if ({spi_ready, st_next, head_idx} !== {1'b1, 1'b0, 4'd5}) begin
            miscompares++;
            $display("FAIL spi_done: got ready=%b next=%b head=%0d expected 1 0 5", spi_ready, st_next, head_idx);
        end
    endtask

    task automatic test_realign();
        apply_reset();
        spi_shift();
        spi_shift();
        #2;
        vectors++;
        if (head_idx !== 4'd2) begin
            miscompares++;
            $display("FAIL realign_start_head: got %0d expected 2", head_idx);
        end
        frame_pulse = 1'b1;
        #2;
        vectors++;
        if ({busy, st_next} !== 2'b00) begin
            miscompares++;
            $display("FAIL frame_cycle: got busy=%b next=%b expected 0 0", busy, st_next);
        end
        step();
        for (int i = 0; i < 14; i++) begin
            frame_pulse = (i == 5);
            #2;
            vectors++;
            if ({st_next, busy, st_write} !== 3'b110) begin
                miscompares++;
                $display("FAIL realign_step_%0d: got next=%b busy=%b write=%b expected 1 1 0", i, st_next, busy, st_write);
            end
            step();
        end
        frame_pulse = 1'b0;
        #2;
        vectors++;
        if ({head_idx, busy, st_next} !== {4'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL realign_done: got head=%0d busy=%b next=%b expected 0 0 0", head_idx, busy, st_next);
        end
    endtask

    task automatic test_realign_interleave();
        apply_reset();
        vid_next = 1'b1;
        repeat (15) step();
        vid_next = 1'b0;
        #2;
        vectors++;
        if (head_idx !== 4'd15) begin
            miscompares++;
            $display("FAIL interleave_head: got %0d expected 15", head_idx);
        end
        frame_pulse = 1'b1;
        step();
        frame_pulse = 1'b0;
        vid_next    = 1'b1;
        #2;
        vectors++;
        if ({st_next, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL interleave_step: got next=%b busy=%b expected 1 1", st_next, busy);
        end
        step();
        vid_next = 1'b0;
        #2;
        vectors++;
        if ({head_idx, busy, st_next} !== {4'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL interleave_done: got head=%0d busy=%b next=%b expected 0 0 0", head_idx, busy, st_next);
        end
    endtask

    task automatic test_wrap_reset();
        apply_reset();
        vid_next = 1'b1;
        repeat (17) step();
        vid_next = 1'b0;
        #2;
        vectors++;
        if (head_idx !== 4'd1) begin
            miscompares++;
            $display("FAIL wrap_head: got %0d expected 1", head_idx);
        end
        frame_pulse = 1'b1;
        step();
        frame_pulse = 1'b0;
        spi_valid   = 1'b1;
        spi_op      = SPI_OP_WRITE;
        spi_line    = 13'h0F0F;
        step();
        spi_valid = 1'b0;
        #2;
        vectors++;
        if ({busy, spi_ready, st_next, head_idx} !== {1'b1, 1'b0, 1'b1, 4'd2}) begin
            miscompares++;
            $display("FAIL mid_realign: got busy=%b ready=%b next=%b head=%0d expected 1 0 1 2",
                     busy, spi_ready, st_next, head_idx);
        end
        nRst = 1'b0;
        #1;
        vectors++;
        if ({st_next, st_write, st_line, head_idx, busy, spi_ready} !== {1'b0, 1'b0, 13'h0, 4'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: got next=%b write=%b line=%h head=%0d busy=%b ready=%b expected 0 0 0000 0 0 1",
                     st_next, st_write, st_line, head_idx, busy, spi_ready);
        end
        step();
        nRst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_video_priority();
        test_spi_blanking();
        test_realign();
        test_realign_interleave();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
